// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz front end and game core: FSM encoding,
// operator codes and small helpers for the answer-switch vectors.
package quiz_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int NUM_SW = 4;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Only called when exactly one bit is set; other patterns map to OP_ADD.
    function automatic logic [1:0] onehot_index(input logic [NUM_SW-1:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = OP_ADD;
            4'b0010: idx = OP_SUB;
            4'b0100: idx = OP_MUL;
            4'b1000: idx = OP_DIV;
            default: idx = OP_ADD;
        endcase
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [NUM_SW-1:0] v);
        return (v & (v - NUM_SW'(1))) != '0;
    endfunction

endpackage

// File: rtl/quiz_input_conditioner_debounce_channel.sv
// One input channel: 2-flop synchroniser, debounce counter, stable level
// register and a registered rising-edge strobe.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise    <= level & ~level_d;
            // Any return to the stable value restarts the count from zero.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/quiz_input_conditioner.sv
// Quiz front end: debounces set/answer inputs and gates answers through an
// IDLE/ARMED/LOCKED window. Optional answer-window timer: QUIZ_TIMEOUT_EN.
module quiz_input_conditioner
    import quiz_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_raw,
    input  logic [NUM_SW-1:0] switch_raw,
    output logic              set_pulse,
    output logic              answer_valid,
    output logic [1:0]        answer_code,
    output logic              multi_press,
    output logic              armed,
    output logic              timeout
);

    logic              unused_set_level;
    logic              set_rise;
    logic [NUM_SW-1:0] sw_level;
    logic [NUM_SW-1:0] sw_rise;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
        .clk   (clk),
        .reset (reset),
        .raw   (set_raw),
        .level (unused_set_level),
        .rise  (set_rise)
    );

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw (
            .clk   (clk),
            .reset (reset),
            .raw   (switch_raw[i]),
            .level (sw_level[i]),
            .rise  (sw_rise[i])
        );
    end

    state_t     state;
    state_t     state_next;
    logic       set_pulse_d;
    logic       answer_valid_d;
    logic [1:0] code_d;
    logic       multi_d;
    logic       timeout_d;
    logic       rearm;
    logic       expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority in ARMED: answer rises, then set (re-arm), then expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (set_rise) state_next = ARMED;
            end
            ARMED: begin
                if (sw_rise != '0) begin
                    if (!more_than_one(sw_rise)) state_next = LOCKED;
                end else if (!set_rise && expired) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (sw_level == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        set_pulse_d    = 1'b0;
        answer_valid_d = 1'b0;
        code_d         = 2'd0;
        multi_d        = 1'b0;
        timeout_d      = 1'b0;
        rearm          = 1'b0;
        case (state)
            IDLE: begin
                set_pulse_d = set_rise;
            end
            ARMED: begin
                if (sw_rise != '0) begin
                    if (more_than_one(sw_rise)) begin
                        multi_d = 1'b1;
                    end else begin
                        answer_valid_d = 1'b1;
                        code_d         = onehot_index(sw_rise);
                    end
                end else if (set_rise) begin
                    set_pulse_d = 1'b1;
                    rearm       = 1'b1;
                end else if (expired) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_pulse    <= 1'b0;
            answer_valid <= 1'b0;
            answer_code  <= 2'd0;
            multi_press  <= 1'b0;
            armed        <= 1'b0;
        end else begin
            set_pulse    <= set_pulse_d;
            answer_valid <= answer_valid_d;
            answer_code  <= code_d;
            multi_press  <= multi_d;
            armed        <= (state == ARMED);
        end
    end

`ifdef QUIZ_TIMEOUT_EN
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] timer;

    // The window is timed from the cycle the armed output is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'd0;
        end else if (state != ARMED || rearm) begin
            timer <= 32'd0;
        end else if (armed) begin
            timer <= timer + 32'd1;
        end
    end

    assign expired = armed && (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    logic unused_timer_cfg;

    assign expired          = 1'b0;
    assign timeout          = 1'b0;
    assign unused_timer_cfg = timeout_d | rearm | (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_quiz_input_conditioner.sv
// Directed bench for quiz_input_conditioner with a strobe scoreboard keyed
// on the cycle each strobe is expected.
module tb_quiz_input_conditioner;
    import quiz_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 20;
    localparam int W   = 22;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_raw = 1'b0;
    logic [3:0] switch_raw = 4'b0000;
    logic       set_pulse;
    logic       answer_valid;
    logic [1:0] answer_code;
    logic       multi_press;
    logic       armed;
    logic       timeout;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_v;
    logic [W-1:0] exp_v;

`ifdef QUIZ_TIMEOUT_EN
    localparam logic EXP_ARMED_AFTER_WINDOW = 1'b0;
`else
    localparam logic EXP_ARMED_AFTER_WINDOW = 1'b1;
`endif

    quiz_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .set_raw      (set_raw),
        .switch_raw   (switch_raw),
        .set_pulse    (set_pulse),
        .answer_valid (answer_valid),
        .answer_code  (answer_code),
        .multi_press  (multi_press),
        .armed        (armed),
        .timeout      (timeout)
    );

    assign outs = {set_pulse, answer_valid, answer_code, multi_press, armed, timeout};

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ev(input int at, input logic sp, input logic av,
                                        input logic [1:0] code, input logic mp,
                                        input logic to);
        return {16'(at), sp, av, code, mp, to};
    endfunction

    // Monitor: every strobe the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (!reset && (set_pulse || answer_valid || multi_press || timeout)) begin
            act_v = {cyc[15:0], set_pulse, answer_valid,
                     (answer_valid ? answer_code : 2'b00), multi_press, timeout};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got cyc=%0d bits=%b, expected no strobe",
                         act_v[W-1:6], act_v[5:0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL strobe_event: got cyc=%0d bits=%b, expected cyc=%0d bits=%b",
                             act_v[W-1:6], act_v[5:0], exp_v[W-1:6], exp_v[5:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int c;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 7'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Set press: pulse DEB+4 edges after the raw rise, armed one edge later.
        c = cyc;
        set_raw = 1'b1;
        exp_q.push_back(ev(c + 8, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        wait_until(c + 8);
        check("armed_lags_set_pulse", {6'b0, armed}, 7'd0);
        wait_until(c + 9);
        check("armed_after_set", {6'b0, armed}, 7'd1);
        wait_until(c + 10);
        set_raw = 1'b0;

        // Two-cycle glitches on the mul switch, then a held press.
        for (int g = 0; g < 2; g++) begin
            switch_raw = 4'b0100;
            wait_until(cyc + 2);
            switch_raw = 4'b0000;
            wait_until(cyc + 2);
        end
        c = cyc;
        switch_raw = 4'b0100;
        exp_q.push_back(ev(c + 8, 1'b0, 1'b1, OP_MUL, 1'b0, 1'b0));
        wait_until(c + 9);
        check("armed_drops_after_answer", {6'b0, armed}, 7'd0);
        wait_until(c + 10);
        switch_raw = 4'b0000;

        // Re-arm from IDLE, double press, then a single sub answer.
        wait_until(c + 20);
        c = cyc;
        set_raw = 1'b1;
        exp_q.push_back(ev(c + 8, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        wait_until(c + 6);
        set_raw = 1'b0;
        wait_until(c + 8);
        switch_raw = 4'b0011;
        exp_q.push_back(ev(c + 16, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
        wait_until(c + 13);
        switch_raw = 4'b0000;
        wait_until(c + 17);
        check("armed_after_multi", {6'b0, armed}, 7'd1);
        wait_until(c + 19);
        switch_raw = 4'b0010;
        exp_q.push_back(ev(c + 27, 1'b0, 1'b1, OP_SUB, 1'b0, 1'b0));
        wait_until(c + 28);
        check("armed_drops_after_sub", {6'b0, armed}, 7'd0);
        wait_until(c + 30);
        switch_raw = 4'b0000;

        // Add switch held before set: ignored until released and pressed again.
        wait_until(c + 40);
        c = cyc;
        switch_raw = 4'b0001;
        wait_until(c + 10);
        set_raw = 1'b1;
        exp_q.push_back(ev(c + 18, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        wait_until(c + 16);
        set_raw = 1'b0;
        wait_until(c + 19);
        check("armed_with_held_switch", {6'b0, armed}, 7'd1);
        wait_until(c + 20);
        switch_raw = 4'b0000;
        wait_until(c + 26);
        switch_raw = 4'b0001;
        exp_q.push_back(ev(c + 34, 1'b0, 1'b1, OP_ADD, 1'b0, 1'b0));

        // LOCKED with div held: set suppressed until all switches release.
        wait_until(c + 36);
        c = cyc;
        switch_raw = 4'b1001;
        wait_until(c + 7);
        switch_raw = 4'b1000;
        wait_until(c + 10);
        set_raw = 1'b1;
        wait_until(c + 16);
        set_raw = 1'b0;
        wait_until(c + 20);
        check("locked_ignores_set", {6'b0, armed}, 7'd0);
        switch_raw = 4'b0000;
        wait_until(c + 30);
        set_raw = 1'b1;
        exp_q.push_back(ev(c + 38, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        wait_until(c + 36);
        set_raw = 1'b0;
        wait_until(c + 39);
        check("armed_after_unlock", {6'b0, armed}, 7'd1);

        // Unanswered window: expires TMO edges after armed rises when enabled.
`ifdef QUIZ_TIMEOUT_EN
        exp_q.push_back(ev(c + 59, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
`endif
        wait_until(c + 58);
        check("armed_before_expiry", {6'b0, armed}, 7'd1);
        wait_until(c + 60);
        check("armed_after_window", {6'b0, armed}, {6'b0, EXP_ARMED_AFTER_WINDOW});

        // Fresh window, then reset in the middle of it.
        wait_until(c + 64);
        set_raw = 1'b1;
        exp_q.push_back(ev(c + 72, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        wait_until(c + 70);
        set_raw = 1'b0;
        wait_until(c + 76);
        check("armed_before_reset", {6'b0, armed}, 7'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_window", outs, 7'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("idle_after_reset", outs, 7'b0);

        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe_missing: got no strobe, expected cyc=%0d bits=%b",
                     exp_v[W-1:6], exp_v[5:0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quiz_input_conditioner.md
Name: quiz_input_conditioner

Overview:
Front-end stage that sits directly upstream of the quiz game core. It synchronises, debounces and edge-detects the raw `set` button and the four operator-answer switches. It then gates them through an answer-window state machine. The game core receives clean one-cycle pulses: one new-question strobe and at most one accepted answer per question.

Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive cycles a synchronised input must differ from its stable value before the stable value flips (1 ms at 50 MHz).
- CNT_W, default 16: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- TIMEOUT_CYCLES, default 500000000: answer-window length. Used only when QUIZ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- set_raw  in  1  raw new-question button.
- switch_raw  in  4  raw answer switches; index 0..3 = add, sub, mul, div.
- set_pulse  out  1  one-cycle strobe: new question requested.
- answer_valid  out  1  one-cycle strobe: an answer was accepted.
- answer_code  out  2  index of the accepted switch; valid only while answer_valid=1.
- multi_press  out  1  one-cycle strobe: two or more answer switches rose in the same cycle.
- armed  out  1  high while an answer window is open.
- timeout  out  1  one-cycle strobe: the answer window expired.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high and takes effect immediately. All flops clear: synchroniser stages, stable values, counters, state=IDLE. All outputs are 0 during and immediately after reset.
- Synchroniser: 2 flops per raw input (5 channels).
- Debounce, per channel:
  - If sync == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, stable <= sync and the counter clears.
  - Any glitch that returns to the stable value before the count completes restarts the count.
- Edge detect: rise = stable & ~stable_d (registered).
- Latency: a raw input held steady produces its rise DEBOUNCE_CYCLES+3 clock edges after the raw change. Output strobes are registered and appear on the following edge.
- Input held through reset release: stable resets to 0, so the held input is treated as a fresh press after the debounce time.
- FSM states: IDLE, ARMED, LOCKED.
  - IDLE:
    - set rise -> set_pulse=1, go to ARMED.
    - Answer rises are ignored.
    - If set and an answer rise in the same cycle, set wins and the answer is dropped.
  - ARMED, exactly one answer rise:
    - answer_valid=1 and answer_code=index for one cycle, go to LOCKED.
    - If a set rise occurs in the same cycle, the answer is accepted and the set is dropped.
  - ARMED, two or more answer rises in the same cycle: multi_press=1 for one cycle, no answer_valid, stay in ARMED.
  - ARMED, set rise with no answer rise: set_pulse=1 (re-arm), stay in ARMED; the timeout timer restarts.
  - ARMED, switch entry condition: a switch already stable-high when ARMED is entered is ignored until it is released and pressed again, because acceptance is edge-based.
  - LOCKED:
    - set rises are suppressed (no set_pulse).
    - Go to IDLE on the first cycle in which all four stable switch values are 0.
- armed = (state == ARMED), registered.
- answer_valid and multi_press are never asserted in the same cycle.
- Reset asserted mid-window returns the block to IDLE; no strobe is emitted.

Optional Feature:
- Macro: QUIZ_TIMEOUT_EN.
- When defined:
  - A 32-bit timer runs only in ARMED. It clears on entry to ARMED and on a re-arm.
  - When the timer reaches TIMEOUT_CYCLES-1 with no answer, timeout=1 for one cycle and the FSM goes to LOCKED.
  - If an answer rise and expiry occur in the same cycle, the answer wins and timeout is not asserted.
- When not defined: no timer is instantiated and timeout is tied to 0.

Decomposition:
- Shared package quiz_pkg:
  - FSM state encoding: IDLE=2'd0, ARMED=2'd1, LOCKED=2'd2.
  - Operator codes: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3. The game core uses the same codes.
  - NUM_SW=4.
- One sub-module, debounce_channel: synchroniser, counter, stable register and rise output. It is instantiated 5 times. FSM and priority logic stay in the top level.

Test Plan (all scenarios run with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=20):
1. Reset, then set_raw high held for 10 cycles -> set_pulse high for exactly 1 cycle, 8 edges after the raw rise; armed=1 from the next cycle.
2. Armed; switch_raw=4'b0100 with 2-cycle glitches, then held -> no strobe during the glitches; then answer_valid=1 with answer_code=2 once; armed=0. Release switch -> state IDLE.
3. Armed; switch_raw 4'b0000 -> 4'b0011 on the same edge -> multi_press=1 for 1 cycle, answer_valid stays 0, armed stays 1.
4. switch_raw[0] held high before set, then set pressed -> armed=1 with no answer_valid. Release switch[0] and press it again -> answer_valid=1, answer_code=0.
5. LOCKED with switch[3] held; press set -> no set_pulse. Release the switch -> IDLE. Press set -> set_pulse=1.
6. With QUIZ_TIMEOUT_EN defined: arm, no answer -> timeout=1 exactly 20 cycles after armed rises, then LOCKED. Repeat the run without the macro -> timeout stays 0 and armed stays 1. A second run asserts reset mid-window -> all outputs 0 immediately.
